// File: rtl/nanov_regfile_sequencer_pkg.sv
// rtl/nanov_regfile_sequencer_pkg.sv - shared types and constants for the regfile window sequencer
package nanov_seq_pkg;

  localparam int XLEN      = 32;
  localparam int BIT_CNT_W = 5;
  localparam logic [BIT_CNT_W-1:0] BIT_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CORE   = 2'd1,
    ST_DBG_RD = 2'd2,
    ST_DBG_WR = 2'd3
  } seq_state_e;

endpackage

// File: rtl/nanov_regfile_sequencer_if.sv
// rtl/nanov_regfile_sequencer_if.sv - core, debug and register-file signals of the window sequencer
interface nanov_regfile_sequencer_if #(
  parameter int REG_ADDR_BITS = 4
);
  import nanov_seq_pkg::*;

  logic [BIT_CNT_W-1:0]     bit_cnt;
  logic                     core_valid;
  logic [REG_ADDR_BITS-1:0] core_rs1;
  logic [REG_ADDR_BITS-1:0] core_rs2;
  logic [REG_ADDR_BITS-1:0] core_rd;
  logic                     core_wr;
  logic                     core_start;
  logic                     alu_data_rd;
  logic                     alu_data_rd_next;
  logic [REG_ADDR_BITS-1:0] rs1;
  logic [REG_ADDR_BITS-1:0] rs2;
  logic [REG_ADDR_BITS-1:0] rd;
  logic [REG_ADDR_BITS-1:0] next_rs1;
  logic [REG_ADDR_BITS-1:0] next_rs2;
  logic                     wr_en;
  logic                     wr_next_en;
  logic                     read_through;
  logic                     data_rd;
  logic                     data_rd_next;
  logic                     data_rs1;
  logic                     dbg_req;
  logic                     dbg_we;
  logic [REG_ADDR_BITS-1:0] dbg_addr;
  logic [XLEN-1:0]          dbg_wdata;
  logic [XLEN-1:0]          dbg_rdata;
  logic                     dbg_done;

  modport slave (
    input  core_valid, core_rs1, core_rs2, core_rd, core_wr, alu_data_rd, alu_data_rd_next,
    input  data_rs1, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output bit_cnt, core_start, rs1, rs2, rd, next_rs1, next_rs2, wr_en, wr_next_en,
    output read_through, data_rd, data_rd_next, dbg_rdata, dbg_done
  );

  modport master (
    output core_valid, core_rs1, core_rs2, core_rd, core_wr, alu_data_rd, alu_data_rd_next,
    output data_rs1, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  bit_cnt, core_start, rs1, rs2, rd, next_rs1, next_rs2, wr_en, wr_next_en,
    input  read_through, data_rd, data_rd_next, dbg_rdata, dbg_done
  );

endinterface

// File: rtl/nanov_regfile_sequencer_dbg_serdes.sv
// rtl/nanov_regfile_sequencer_dbg_serdes.sv - debug word serialiser and LSB-first deserialiser
module nanov_dbg_serdes
  import nanov_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BIT_CNT_W-1:0] bit_cnt_i,
  input  logic                 wdata_load_i,
  input  logic [XLEN-1:0]      wdata_i,
  output logic                 wbit_o,
  output logic                 wbit_next_o,
  input  logic                 rd_shift_i,
  input  logic                 rd_done_i,
  input  logic                 rbit_i,
  output logic [XLEN-1:0]      rdata_o
);

  logic [XLEN-1:0]      wdata_q, wdata_d;
  logic [XLEN-1:0]      rshift_q, rshift_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic [BIT_CNT_W-1:0] bit_next;

  assign bit_next = bit_cnt_i + BIT_CNT_W'(1);

  always_comb begin
    wdata_d  = wdata_q;
    rshift_d = rshift_q;
    rdata_d  = rdata_q;
    if (wdata_load_i) wdata_d = wdata_i;
    if (rd_shift_i) rshift_d = {rbit_i, rshift_q[XLEN-1:1]};
    // the last bit arrives on the same cycle the word is published
    if (rd_done_i) rdata_d = {rbit_i, rshift_q[XLEN-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wdata_q  <= '0;
      rshift_q <= '0;
      rdata_q  <= '0;
    end else begin
      wdata_q  <= wdata_d;
      rshift_q <= rshift_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wbit_o      = wdata_q[bit_cnt_i];
  assign wbit_next_o = wdata_q[bit_next];
  assign rdata_o     = rdata_q;

endmodule

// File: rtl/nanov_regfile_sequencer.sv
// rtl/nanov_regfile_sequencer.sv - 32-cycle window arbiter and control for the bit-serial RV32E regfile
module nanov_regfile_sequencer
  import nanov_seq_pkg::*;
#(
  parameter int NUM_REGS         = 16,
  parameter int REG_ADDR_BITS    = 4,
  parameter int DBG_STARVE_LIMIT = 4
) (
  input logic                        clk,
  input logic                        rstn,
  nanov_regfile_sequencer_if.slave   bus
);

  localparam int SC_W = $clog2(DBG_STARVE_LIMIT + 1);

  logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  seq_state_e               state_q, state_d, arb_state;
  logic [SC_W-1:0]          starve_q, starve_d;
  logic [REG_ADDR_BITS-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [REG_ADDR_BITS-1:0] arb_rs1, arb_rs2, arb_rd;
  logic                     wr_q, wr_d, arb_wr;
  logic                     done_q, done_d;
  logic                     last, in_dbg, dbg_pend, dbg_wins;
  logic                     ser_bit, ser_bit_next;

  function automatic logic writable(input logic [REG_ADDR_BITS-1:0] a);
    return (a != '0) && (int'(a) < NUM_REGS);
  endfunction

  assign last   = (bit_cnt_q == BIT_LAST);
  assign in_dbg = (state_q == ST_DBG_RD) || (state_q == ST_DBG_WR);
  // a request still high in the final cycle of its own window is the one being completed
  assign dbg_pend = bus.dbg_req && !in_dbg;
  assign dbg_wins = dbg_pend && (!bus.core_valid || starve_q == SC_W'(DBG_STARVE_LIMIT));

  always_comb begin
    arb_state = ST_IDLE;
    arb_rs1   = '0;
    arb_rs2   = '0;
    arb_rd    = '0;
    arb_wr    = 1'b0;
    if (dbg_wins) begin
      if (bus.dbg_we) begin
        arb_state = ST_DBG_WR;
        arb_rd    = bus.dbg_addr;
        arb_wr    = writable(bus.dbg_addr);
      end else begin
        arb_state = ST_DBG_RD;
        arb_rs1   = bus.dbg_addr;
      end
    end else if (bus.core_valid) begin
      arb_state = ST_CORE;
      arb_rs1   = bus.core_rs1;
      arb_rs2   = bus.core_rs2;
      arb_rd    = bus.core_rd;
      arb_wr    = bus.core_wr && writable(bus.core_rd);
    end
  end

  always_comb begin
    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
    state_d   = state_q;
    starve_d  = starve_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    done_d    = last && in_dbg;
    if (last) begin
      state_d  = arb_state;
      rs1_d    = arb_rs1;
      rs2_d    = arb_rs2;
      rd_d     = arb_rd;
      wr_d     = arb_wr;
      starve_d = (dbg_pend && !dbg_wins) ? starve_q + SC_W'(1) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bit_cnt_q <= '0;
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      state_q   <= state_d;
      starve_q  <= starve_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
    end
  end

  nanov_dbg_serdes u_serdes (
    .clk          (clk),
    .rstn         (rstn),
    .bit_cnt_i    (bit_cnt_q),
    .wdata_load_i (last && arb_state == ST_DBG_WR),
    .wdata_i      (bus.dbg_wdata),
    .wbit_o       (ser_bit),
    .wbit_next_o  (ser_bit_next),
    .rd_shift_i   (state_q == ST_DBG_RD),
    .rd_done_i    (last && state_q == ST_DBG_RD),
    .rbit_i       (bus.data_rs1),
    .rdata_o      (bus.dbg_rdata)
  );

  always_comb begin
    bus.data_rd      = 1'b0;
    bus.data_rd_next = 1'b0;
    case (state_q)
      ST_CORE: begin
        bus.data_rd      = bus.alu_data_rd;
        bus.data_rd_next = bus.alu_data_rd_next;
      end
      ST_DBG_WR: begin
        bus.data_rd      = ser_bit;
        bus.data_rd_next = ser_bit_next;
      end
      default: ;
    endcase
  end

  assign bus.bit_cnt      = bit_cnt_q;
  assign bus.rs1          = rs1_q;
  assign bus.rs2          = rs2_q;
  assign bus.rd           = rd_q;
  assign bus.next_rs1     = last ? arb_rs1 : rs1_q;
  assign bus.next_rs2     = last ? arb_rs2 : rs2_q;
  assign bus.wr_en        = wr_q;
  assign bus.wr_next_en   = last ? arb_wr : wr_q;
  assign bus.read_through = last && wr_q && state_q == ST_CORE && arb_state == ST_CORE;
  assign bus.core_start   = (state_q == ST_CORE) && (bit_cnt_q == '0);
  assign bus.dbg_done     = done_q;

endmodule

// File: tb/tb_nanov_regfile_sequencer.sv
// tb/tb_nanov_regfile_sequencer.sv - directed self-checking bench for the regfile window sequencer
module tb_nanov_regfile_sequencer;

  logic clk;
  logic rstn;
  int   errors = 0;
  int   checks = 0;

  nanov_regfile_sequencer_if #(.REG_ADDR_BITS(4)) bus ();

  nanov_regfile_sequencer #(
    .NUM_REGS(16), .REG_ADDR_BITS(4), .DBG_STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bit-serial register file model: bit k of each register sits at bit_cnt==k
  logic [31:0] rf [16];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (bus.wr_en && bus.rd != 4'd0) begin
      rf[bus.rd][bus.bit_cnt] <= bus.data_rd;
    end
  end
  assign bus.data_rs1 = rf[bus.rs1][bus.bit_cnt];

  task automatic set_idle();
    bus.core_valid = 0; bus.core_rs1 = 0; bus.core_rs2 = 0; bus.core_rd = 0; bus.core_wr = 0;
    bus.alu_data_rd = 0; bus.alu_data_rd_next = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
  endtask

  task automatic wait_cnt(input int k);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (int'(bus.bit_cnt) != k && n < 70);
    checks++;
    if (int'(bus.bit_cnt) != k) begin
      errors++;
      $display("FAIL wait_cnt: bit_cnt=%0d required=%0d", bus.bit_cnt, k);
    end
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    logic       wrapped, bad;
    int         exp_cnt;
    set_idle();
    rstn = 0;
    repeat (3) @(negedge clk);
    ctl = {bus.wr_en, bus.wr_next_en, bus.read_through, bus.core_start, bus.dbg_done, bus.data_rd, bus.data_rd_next};
    checks++; if (bus.bit_cnt !== 5'd0) begin errors++; $display("FAIL reset_bit_cnt: got %0d required 0", bus.bit_cnt); end
    checks++; if ({bus.rs1, bus.rs2, bus.rd, bus.next_rs1, bus.next_rs2} !== 20'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", {bus.rs1, bus.rs2, bus.rd, bus.next_rs1, bus.next_rs2}); end
    checks++; if (ctl !== 7'd0) begin errors++; $display("FAIL reset_ctl: got %b required 0000000", ctl); end
    checks++; if (bus.dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h required 0", bus.dbg_rdata); end
    rstn = 1;
    wrapped = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      exp_cnt = (i + 1) % 32;
      checks++;
      if (int'(bus.bit_cnt) != exp_cnt) begin errors++; $display("FAIL idle_bit_cnt: got %0d required %0d", bus.bit_cnt, exp_cnt); end
      if (i == 31 && bus.bit_cnt === 5'd0) wrapped = 1;
      ctl = {bus.wr_en, bus.wr_next_en, bus.read_through, bus.core_start, bus.dbg_done, bus.data_rd, bus.data_rd_next};
      if (ctl !== 7'd0 || bus.rs1 !== 4'd0) bad = 1;
    end
    checks++; if (!wrapped) begin errors++; $display("FAIL idle_wrap: wrap seen=%0b required 1", wrapped); end
    checks++; if (bad) begin errors++; $display("FAIL idle_ctl: activity seen=%0b required 0", bad); end
  endtask

  task automatic test_core_write();
    logic bad;
    wait_cnt(31);
    bus.core_valid = 1; bus.core_rs1 = 3; bus.core_rs2 = 5; bus.core_rd = 7; bus.core_wr = 1;
    bus.alu_data_rd = 1; bus.alu_data_rd_next = 0;
    #1;
    checks++; if (bus.wr_next_en !== 1'b1 || bus.wr_en !== 1'b0) begin errors++; $display("FAIL core_pre31: wr_next_en=%b wr_en=%b required 1 0", bus.wr_next_en, bus.wr_en); end
    checks++; if (bus.next_rs1 !== 4'd3 || bus.next_rs2 !== 4'd5) begin errors++; $display("FAIL core_next_addr: got %0d/%0d required 3/5", bus.next_rs1, bus.next_rs2); end
    checks++; if (bus.read_through !== 1'b0) begin errors++; $display("FAIL core_rt_idle: got %b required 0", bus.read_through); end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL core_start: got %b required 1", bus.core_start); end
        bus.core_valid = 0;
      end else if (bus.core_start !== 1'b0) bad = 1;
      if (bus.rs1 !== 4'd3 || bus.rs2 !== 4'd5 || bus.rd !== 4'd7) bad = 1;
      if (bus.wr_en !== 1'b1 || bus.wr_next_en !== (k != 31)) bad = 1;
      if (bus.data_rd !== 1'b1 || bus.data_rd_next !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL core_window: mismatch seen=%0b required 0", bad); end
    @(negedge clk);
    checks++; if (bus.wr_en !== 1'b0 || bus.core_start !== 1'b0 || bus.rd !== 4'd0) begin errors++; $display("FAIL core_after: wr_en=%b core_start=%b rd=%0d required 0 0 0", bus.wr_en, bus.core_start, bus.rd); end
    bus.alu_data_rd = 0;
  endtask

  task automatic test_back_to_back();
    logic bad;
    wait_cnt(31);
    bus.core_valid = 1; bus.core_rs1 = 1; bus.core_rs2 = 2; bus.core_rd = 7; bus.core_wr = 1;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL b2b_start_a: got %b required 1", bus.core_start); end
        bus.core_rs1 = 7; bus.core_rs2 = 0; bus.core_rd = 9; bus.core_wr = 1;
      end
      if (k < 31) begin
        if (bus.read_through !== 1'b0 || bus.next_rs1 !== 4'd1) bad = 1;
      end else begin
        #1;
        checks++; if (bus.read_through !== 1'b1) begin errors++; $display("FAIL b2b_read_through: got %b required 1", bus.read_through); end
        checks++; if (bus.next_rs1 !== 4'd7 || bus.next_rs2 !== 4'd0) begin errors++; $display("FAIL b2b_next_rs: got %0d/%0d required 7/0", bus.next_rs1, bus.next_rs2); end
      end
    end
    checks++; if (bad) begin errors++; $display("FAIL b2b_window_a: mismatch seen=%0b required 0", bad); end
    @(negedge clk);
    checks++; if (bus.core_start !== 1'b1 || bus.rs1 !== 4'd7 || bus.rd !== 4'd9) begin errors++; $display("FAIL b2b_start_b: start=%b rs1=%0d rd=%0d required 1 7 9", bus.core_start, bus.rs1, bus.rd); end
    bus.core_valid = 0;
    wait_cnt(31);
    #1;
    checks++; if (bus.read_through !== 1'b0) begin errors++; $display("FAIL b2b_rt_end: got %b required 0", bus.read_through); end
  endtask

  task automatic test_dbg_write_read();
    logic [31:0] w;
    logic        bad;
    w = 32'hDEADBEEF;
    wait_cnt(31);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 4; bus.dbg_wdata = w;
    #1;
    checks++; if (bus.wr_next_en !== 1'b1) begin errors++; $display("FAIL dbgw_pre31: wr_next_en=%b required 1", bus.wr_next_en); end
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (k == 0) bus.dbg_wdata = 32'h0;
      if (bus.rd !== 4'd4 || bus.wr_en !== 1'b1 || bus.dbg_done !== 1'b0) bad = 1;
      if (bus.data_rd !== w[k] || bus.data_rd_next !== w[(k + 1) % 32]) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL dbgw_serialise: mismatch seen=%0b required 0", bad); end
    @(negedge clk);
    checks++; if (bus.dbg_done !== 1'b1) begin errors++; $display("FAIL dbgw_done: got %b required 1", bus.dbg_done); end
    checks++; if (bus.wr_en !== 1'b0 || bus.rd !== 4'd0) begin errors++; $display("FAIL dbgw_after: wr_en=%b rd=%0d required 0 0", bus.wr_en, bus.rd); end
    bus.dbg_req = 0;
    wait_cnt(31);
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 4;
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.rs1 !== 4'd4 || bus.rd !== 4'd0 || bus.wr_en !== 1'b0 || bus.dbg_done !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL dbgr_window: mismatch seen=%0b required 0", bad); end
    @(negedge clk);
    checks++; if (bus.dbg_done !== 1'b1) begin errors++; $display("FAIL dbgr_done_latency: got %b required 1 at cycle 32", bus.dbg_done); end
    checks++; if (bus.dbg_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dbgr_rdata: got %h required deadbeef", bus.dbg_rdata); end
    bus.dbg_req = 0;
    @(negedge clk);
    checks++; if (bus.dbg_done !== 1'b0) begin errors++; $display("FAIL dbgr_done_pulse: got %b required 0", bus.dbg_done); end
  endtask

  task automatic test_starve();
    wait_cnt(31);
    bus.core_valid = 1; bus.core_rs1 = 1; bus.core_rs2 = 2; bus.core_rd = 3; bus.core_wr = 0;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 5;
    for (int w = 0; w < 4; w++) begin
      wait_cnt(0);
      checks++; if (bus.core_start !== 1'b1 || bus.rs1 !== 4'd1) begin errors++; $display("FAIL starve_core%0d: start=%b rs1=%0d required 1 1", w, bus.core_start, bus.rs1); end
    end
    wait_cnt(0);
    checks++; if (bus.core_start !== 1'b0 || bus.rs1 !== 4'd5 || bus.rs2 !== 4'd0) begin errors++; $display("FAIL starve_dbg: start=%b rs1=%0d rs2=%0d required 0 5 0", bus.core_start, bus.rs1, bus.rs2); end
    wait_cnt(0);
    checks++; if (bus.dbg_done !== 1'b1 || bus.dbg_rdata !== 32'd0) begin errors++; $display("FAIL starve_dbg_done: done=%b rdata=%h required 1 0", bus.dbg_done, bus.dbg_rdata); end
    checks++; if (bus.core_start !== 1'b1 || bus.rs1 !== 4'd1) begin errors++; $display("FAIL starve_resume: start=%b rs1=%0d required 1 1", bus.core_start, bus.rs1); end
    bus.dbg_req = 0;
    bus.core_valid = 0;
    wait_cnt(0);
    checks++; if (bus.core_start !== 1'b0 || bus.rs1 !== 4'd0) begin errors++; $display("FAIL starve_idle: start=%b rs1=%0d required 0 0", bus.core_start, bus.rs1); end
  endtask

  task automatic test_x0_write();
    logic bad;
    wait_cnt(31);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 0; bus.dbg_wdata = 32'hFFFFFFFF;
    #1;
    bad = (bus.wr_next_en !== 1'b0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (bus.wr_en !== 1'b0 || bus.wr_next_en !== 1'b0 || bus.dbg_done !== 1'b0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL x0_enables: enable seen=%0b required 0", bad); end
    @(negedge clk);
    checks++; if (bus.dbg_done !== 1'b1) begin errors++; $display("FAIL x0_done: got %b required 1", bus.dbg_done); end
    bus.dbg_req = 0;
  endtask

  task automatic test_reset_mid();
    logic bad;
    wait_cnt(31);
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 4;
    wait_cnt(12);
    checks++; if (bus.rs1 !== 4'd4) begin errors++; $display("FAIL mid_in_window: rs1=%0d required 4", bus.rs1); end
    rstn = 0;
    bus.dbg_req = 0;
    @(negedge clk);
    checks++; if (bus.bit_cnt !== 5'd0 || bus.rs1 !== 4'd0 || bus.dbg_done !== 1'b0) begin errors++; $display("FAIL mid_reset: cnt=%0d rs1=%0d done=%b required 0 0 0", bus.bit_cnt, bus.rs1, bus.dbg_done); end
    checks++; if (bus.dbg_rdata !== 32'd0) begin errors++; $display("FAIL mid_rdata: got %h required 0", bus.dbg_rdata); end
    rstn = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.dbg_done !== 1'b0 || bus.core_start !== 1'b0 || bus.rs1 !== 4'd0) bad = 1;
    end
    checks++; if (bad) begin errors++; $display("FAIL mid_after: pulse or window seen=%0b required 0", bad); end
  endtask

  initial begin
    test_reset();
    test_core_write();
    test_back_to_back();
    test_dbg_write_read();
    test_starve();
    test_x0_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
